// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared definitions for the bit-serial subtractor
// Purpose: FSM state encoding and default operand width for serial_subtractor.
// Ports: none (package).
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - single-bit combinational full subtractor cell
// Purpose: computes one bit of a - b - bin and the borrow into the next bit.
// Ports:
//   a   in  minuend bit
//   b   in  subtrahend bit
//   bin in  borrow from the previous (less significant) bit
//   d   out difference bit
//   bo  out borrow out to the next (more significant) bit
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bin;
  // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
  assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial multi-cycle subtractor, LSB first
// Purpose: computes {bout,diff} = a - b - bin one bit per clock using a single
// full_subtractor cell and a registered borrow. start is honoured only in IDLE;
// the result registers update only on entry to DONE and hold until the next one.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow output.
// Ports:
//   clk   in  rising-edge clock
//   rst_n in  synchronous active-low reset
//   start in  operation request, sampled in IDLE
//   a     in  WIDTH  minuend, captured on accept
//   b     in  WIDTH  subtrahend, captured on accept
//   bin   in  borrow-in, captured on accept
//   busy  out high while shifting (WIDTH cycles)
//   done  out one-cycle pulse while in DONE
//   diff  out WIDTH  difference
//   bout  out borrow-out
//   ovf   out signed overflow (SERIAL_SUB_OVF_EN only)
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             bout,
  output logic             ovf
`else
  output logic             bout
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Only the upper WIDTH-1 result bits need storing: the final bit goes
  // straight from the cell into diff on the last shift.
  logic [WIDTH-2:0] d_sh;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             fs_d;
  logic             fs_bo;
  logic [WIDTH-1:0] d_next;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  full_subtractor u_fs (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .bin (brw),
    .d   (fs_d),
    .bo  (fs_bo)
  );

  // New bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB result.
  assign d_next = {fs_d, d_sh};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      d_sh  <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            brw   <= bin;
            cnt   <= '0;
            d_sh  <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end

        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          d_sh <= d_next[WIDTH-1:1];
          brw  <= fs_bo;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= d_next;
            bout  <= fs_bo;
            state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            // Operands of differing sign whose result sign differs from a.
            ovf   <= (a_msb != b_msb) && (fs_d != a_msb);
`endif
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start4, bin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, bout4, ovf4;
  logic [3:0] diff4;

  logic       start8, bin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, bout8, ovf8;
  logic [7:0] diff8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .bin   (bin4),
    .busy  (busy4),
    .done  (done4),
    .diff  (diff4),
`ifdef SERIAL_SUB_OVF_EN
    .bout  (bout4),
    .ovf   (ovf4)
`else
    .bout  (bout4)
`endif
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
`ifdef SERIAL_SUB_OVF_EN
    .bout  (bout8),
    .ovf   (ovf8)
`else
    .bout  (bout8)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf4 = 1'b0;
  assign ovf8 = 1'b0;
`endif

  // Directed vectors: {a, b, bin, diff, bout, ovf}
  logic [14:0] vecs [0:8] = '{
    {4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0},
    {4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 1'b0},
    {4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0},
    {4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0},
    {4'b0111, 4'b1111, 1'b0, 4'b1000, 1'b1, 1'b1},
    {4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1},
    {4'b1010, 4'b0101, 1'b0, 4'b0101, 1'b0, 1'b1},
    {4'b0110, 4'b0011, 1'b0, 4'b0011, 1'b0, 1'b0},
    {4'b1001, 4'b0010, 1'b0, 4'b0111, 1'b0, 1'b1}
  };

  function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    int r;
    r = int'(a) - int'(b) - int'(bi);
    return 5'(r);
  endfunction

  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic bi);
    int r;
    r = int'(a) - int'(b) - int'(bi);
    return 9'(r);
  endfunction

  // Runs one 4-bit operation from IDLE; returns results, latency in edges
  // (accept edge counted as 1), busy cycles and whether done fell after one cycle.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi,
                     output logic [3:0] d, output logic bo, output logic ov,
                     output int lat, output int bcyc, output logic single);
    a4 = a; b4 = b; bin4 = bi; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    lat = 1; bcyc = 0;
    while (!done4 && lat < 20) begin
      if (busy4) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
    d = diff4; bo = bout4; ov = ovf4;
    @(posedge clk); #1;
    single = !done4;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                     output logic [7:0] d, output logic bo, output logic ov, output int lat);
    a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1;
    while (!done8 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    d = diff8; bo = bout8; ov = ovf8;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; bin4 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy4); end
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done4); end
    checks++; if ({bout4, diff4} !== 5'b0) begin errors++; $display("FAIL reset_result: got %b expected 00000", {bout4, diff4}); end
    checks++; if ({busy8, done8, bout8, diff8} !== 11'b0) begin errors++; $display("FAIL reset_dut8: got %b expected 0", {busy8, done8, bout8, diff8}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [3:0] d; logic bo, ov, single; int lat, bcyc;
    for (int i = 0; i < 9; i++) begin
      logic [14:0] v;
      v = vecs[i];
      op4(v[14:11], v[10:7], v[6], d, bo, ov, lat, bcyc, single);
      checks++; if ({bo, d} !== {v[1], v[5:2]}) begin errors++; $display("FAIL directed%0d_result: got %b expected %b", i, {bo, d}, {v[1], v[5:2]}); end
`ifdef SERIAL_SUB_OVF_EN
      checks++; if (ov !== v[0]) begin errors++; $display("FAIL directed%0d_ovf: got %b expected %b", i, ov, v[0]); end
`endif
      if (i == 0) begin
        checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d expected 5", lat); end
        checks++; if (bcyc !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 4", bcyc); end
        checks++; if (single !== 1'b1) begin errors++; $display("FAIL basic_done_single: got %b expected 1", single); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    a4 = 4'b0101; b4 = 4'b0011; bin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if ({busy4, done4} !== 2'b00) begin errors++; $display("FAIL midreset_flags: got %b expected 00", {busy4, done4}); end
    checks++; if ({bout4, diff4} !== 5'b0) begin errors++; $display("FAIL midreset_result: got %b expected 00000", {bout4, diff4}); end
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin @(posedge clk); #1; if (done4 || busy4) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_done: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_start_held();
    int idx[$];
    a4 = 4'd9; b4 = 4'd2; bin4 = 1'b0; start4 = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done4) idx.push_back(k);
    end
    start4 = 1'b0;
    checks++; if (idx.size() !== 5) begin errors++; $display("FAIL held_pulse_count: got %0d expected 5", idx.size()); end
    if (idx.size() > 0) begin
      checks++; if (idx[0] !== 5) begin errors++; $display("FAIL held_first_done: got %0d expected 5", idx[0]); end
    end
    for (int j = 1; j < idx.size(); j++) begin
      checks++; if (idx[j] - idx[j-1] !== 6) begin errors++; $display("FAIL held_spacing%0d: got %0d expected 6", j, idx[j] - idx[j-1]); end
    end
    checks++; if ({bout4, diff4} !== 5'b00111) begin errors++; $display("FAIL held_result: got %b expected 00111", {bout4, diff4}); end
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_start_ignored();
    int lat, extra;
    a4 = 4'b0101; b4 = 4'b0011; bin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 1;
    repeat (2) begin @(posedge clk); #1; lat++; end
    a4 = 4'b0000; b4 = 4'b1111; bin4 = 1'b1; start4 = 1'b1;
    @(posedge clk); #1; lat++;
    start4 = 1'b0;
    while (!done4 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 5) begin errors++; $display("FAIL ignore_latency: got %0d expected 5", lat); end
    checks++; if ({bout4, diff4} !== 5'b00010) begin errors++; $display("FAIL ignore_result: got %b expected 00010", {bout4, diff4}); end
    extra = 0;
    repeat (10) begin @(posedge clk); #1; if (done4) extra++; end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_no_second_op: got %0d done cycles expected 0", extra); end
  endtask

  task automatic test_random4();
    logic [3:0] a, b, d; logic bi, bo, ov, single; logic [4:0] e; int lat, bcyc;
    for (int i = 0; i < 500; i++) begin
      a = 4'($urandom); b = 4'($urandom); bi = 1'($urandom);
      op4(a, b, bi, d, bo, ov, lat, bcyc, single);
      e = ref4(a, b, bi);
      checks++; if ({bo, d} !== e) begin errors++; $display("FAIL rand4 %h-%h-%b: got %b expected %b", a, b, bi, {bo, d}, e); end
      checks++; if (bo !== (int'(a) < int'(b) + int'(bi))) begin errors++; $display("FAIL rand4_borrow %h-%h-%b: got %b", a, b, bi, bo); end
      checks++; if (lat !== 5 || !single) begin errors++; $display("FAIL rand4_timing: got lat %0d single %b expected 5 1", lat, single); end
`ifdef SERIAL_SUB_OVF_EN
      checks++; if (ov !== ((a[3] != b[3]) && (e[3] != a[3]))) begin errors++; $display("FAIL rand4_ovf %h-%h-%b: got %b", a, b, bi, ov); end
`endif
    end
  endtask

  task automatic test_random8();
    logic [7:0] a, b, d; logic bi, bo, ov; logic [8:0] e; int lat;
    for (int i = 0; i < 500; i++) begin
      a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
      if (i == 0) begin a = 8'h00; b = 8'h00; bi = 1'b1; end
      op8(a, b, bi, d, bo, ov, lat);
      e = ref8(a, b, bi);
      checks++; if ({bo, d} !== e) begin errors++; $display("FAIL rand8 %h-%h-%b: got %b expected %b", a, b, bi, {bo, d}, e); end
      checks++; if (lat !== 9) begin errors++; $display("FAIL rand8_latency: got %0d expected 9", lat); end
`ifdef SERIAL_SUB_OVF_EN
      checks++; if (ov !== ((a[7] != b[7]) && (e[7] != a[7]))) begin errors++; $display("FAIL rand8_ovf %h-%h-%b: got %b", a, b, bi, ov); end
`endif
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_start_held();
    test_start_ignored();
    test_random4();
    test_random8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor; computes a - b - bin one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Arithmetic inverse of the ripple carry adder already in the datapath.
- Serves area-constrained paths and acts as the check-back unit that undoes adder results in verification.
- Simple start/busy/done handshake; operands are captured on start, and results are held until the next accepted start.

Parameters:
- WIDTH, 4, operand/result width in bits (>= 2).
- CNT_W, $clog2(WIDTH)+1, bit counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend, captured when start is accepted.
- b  input  WIDTH  subtrahend, captured when start is accepted.
- bin  input  1  borrow-in, captured when start is accepted.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse in DONE.
- diff  output  WIDTH  difference, valid from done onward.
- bout  output  1  borrow-out, valid from done onward.
- ovf  output  1  signed overflow (only with the optional feature).

Behaviour:
- Reset (rst_n=0 at a clk edge), including mid-operation:
  - state <= IDLE; busy, done, diff, bout, ovf <= 0.
  - Shift registers, bit counter and borrow flop are cleared.
  - Any in-flight operation is discarded.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE with start=1: load a_sh<=a, b_sh<=b, brw<=bin, cnt<=0, clear d_sh; go to SHIFT.
  - IDLE with start=0: remain in IDLE.
  - SHIFT, each edge: full-subtractor on (a_sh[0], b_sh[0], brw).
    - d = a^b^brw; brw_next = (~a&b) | (~(a^b)&brw).
    - d shifts into d_sh MSB-first-in (right shift); a_sh and b_sh shift right; cnt++.
    - When cnt==WIDTH-1 on this edge: go to DONE; diff<=final d_sh; bout<=brw_next.
  - DONE: done=1 for exactly one cycle; unconditionally go to IDLE.
- Timing:
  - busy=1 exactly in SHIFT (WIDTH cycles).
  - done rises WIDTH+1 edges after the start-accept edge.
  - Minimum start-to-start spacing: WIDTH+2 cycles.
- start while busy or done is ignored (no queuing); a, b and bin may change freely after acceptance.
- diff and bout update only on entry to DONE; they hold the prior result through IDLE and SHIFT.
- Arithmetic: {bout,diff} == (a - b - bin) mod 2^(WIDTH+1), zero-extended operands. bout=1 iff a < b+bin (unsigned).
- Wrap-around: 0 - 0 - 1 gives diff = all ones, bout=1.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - ovf port exists.
  - ovf = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), using the captured operand MSBs.
  - ovf updates with diff on entry to DONE; reset value 0.
- Undefined: ovf port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package serial_sub_pkg holds:
  - the state encoding enum (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - default WIDTH constant.
- One sub-module: full_subtractor (combinational: a, b, bin -> d, bo), instantiated once inside serial_subtractor.

Test Plan:
- Reset mid-SHIFT: start a=0101 b=0011, assert rst_n=0 after 2 cycles -> next edge busy=0, done=0, diff=0000, bout=0; no done pulse follows.
- Basic: a=0101 b=0011 bin=0 -> done 5 edges after accept; diff=0010, bout=0; busy high exactly 4 cycles.
- Borrow/wrap:
  - a=0011 b=0101 bin=0 -> diff=1110, bout=1.
  - a=0000 b=0000 bin=1 -> diff=1111, bout=1.
  - a=1111 b=1111 bin=1 -> diff=1111, bout=1.
- Handshake:
  - start held high continuously -> operations start every 6 cycles; done pulses are single-cycle.
  - start pulsed during SHIFT -> ignored; result unchanged.
- Overflow (SERIAL_SUB_OVF_EN):
  - a=0111 b=1111 -> diff=1000, bout=1, ovf=1.
  - a=1000 b=0001 -> diff=0111, bout=0, ovf=1.
  - a=1010 b=0101 -> diff=0101, ovf=1.
  - a=0110 b=0011 -> diff=0011, ovf=0.
- Random sweep: 500 random a/b/bin at WIDTH=4 and WIDTH=8 -> {bout,diff} matches the arithmetic rule and the reference model a - b - bin every time.
